arb_burst_sched: RTL and testbench

- Burst-locking round-robin scheduler that shares one downstream resource among N requesters.
- Each granted requester owns the resource for a whole multi-beat burst, with its length latched at grant time.
- Priority rotates to the requester after the last owner when a burst completes.
- A watchdog aborts a burst that stalls too long.
- Sits between requester ports and the shared resource handshake (req_o/ack_o), one level above the single-cycle round-robin arbiter.

---
 rtl/arb_burst_sched_pkg.sv | 15 +
 rtl/arb_burst_sched_rr_pick.sv | 34 +++
 rtl/arb_burst_sched.sv | 135 +++++++++++++
 tb/tb_arb_burst_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_burst_sched_pkg.sv
// Shared definitions for the burst-locking round-robin scheduler.
// Holds the FSM state encoding and the default parameter widths.
package arb_burst_sched_pkg;

  localparam int N_DEF   = 4;
  localparam int LW_DEF  = 4;
  localparam int TOW_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/arb_burst_sched_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above
// the pointer, wrapping from N-1 back to 0.
module arb_burst_sched_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      // modulo N, not 2^IW, so non-power-of-two N wraps correctly
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/arb_burst_sched.sv
// Burst-locking round-robin scheduler: one owner holds the shared resource
// for a whole burst, with a stall watchdog and a dead cycle between owners.
//
// state   | meaning
// IDLE    | no owner; pick a winner from req_i when any is set
// BUSY    | burst in progress; count acked beats, watch for stalls
// GAP     | one dead cycle after done/abort before the next pick
module arb_burst_sched
  import arb_burst_sched_pkg::*;
#(
  parameter  int N   = N_DEF,
  parameter  int LW  = LW_DEF,
  parameter  int TOW = TOW_DEF,
  localparam int IW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req_i,
  input  logic [N*LW-1:0] len_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] owner_o,
  output logic          busy_o,
  output logic          req_o,
  input  logic          ack_o,
  output logic          last_o,
  output logic          done_o,
  output logic          err_o
);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [TOW-1:0] wd_q, wd_d, wd_inc;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] owner_inc;

  arb_burst_sched_rr_pick #(.N(N)) u_rr_pick (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_inc = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign wd_inc    = wd_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          cnt_d   = len_i[int'(pick_idx)*LW +: LW];
          wd_d    = '0;
        end
      end
      ST_BUSY: begin
        // an ack always beats a saturating watchdog in the same cycle
        if (ack_o) begin
          wd_d = '0;
          if (cnt_q == '0) begin
            state_d = ST_GAP;
            gnt_d   = '0;
            ptr_d   = owner_inc;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else if (&wd_inc) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          ptr_d   = owner_inc;
          err_d   = 1'b1;
          wd_d    = '0;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign busy_o  = (state_q == ST_BUSY);
  assign req_o   = busy_o;
  assign last_o  = busy_o && (cnt_q == '0);
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_arb_burst_sched.sv
// Self-checking bench for arb_burst_sched: a burst-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_arb_burst_sched;

  localparam int N   = 4;
  localparam int LW  = 4;
  localparam int TOW = 3;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_i;
  logic [N*LW-1:0] len_i;
  logic            ack_o;
  logic [N-1:0]    gnt_o;
  logic [IW-1:0]   owner_o;
  logic            busy_o, req_o, last_o, done_o, err_o;

  arb_burst_sched #(.N(N), .LW(LW), .TOW(TOW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (req_i),
    .len_i   (len_i),
    .gnt_o   (gnt_o),
    .owner_o (owner_o),
    .busy_o  (busy_o),
    .req_o   (req_o),
    .ack_o   (ack_o),
    .last_o  (last_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // reference model: burst-level bookkeeping
  int m_busy = 0, m_gap = 0, m_ptr = 0, m_owner = 0;
  int m_left = 0, m_stall = 0, m_done = 0, m_err = 0;
  int cyc = 0;
  int grant_log[$];
  int grant_cyc[$];
  int err_cyc[$];

  int dut_beats = 0, dut_done = 0, dut_err = 0;
  int base_g, base_b, base_d, base_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int len_of(input int i);
    logic [N*LW-1:0] t;
    t = len_i >> (i * LW);
    return int'(t[LW-1:0]);
  endfunction

  function automatic int glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int gcyc(input int i);
    return (i < grant_cyc.size()) ? grant_cyc[i] : -1000;
  endfunction

  function automatic int ecyc(input int i);
    return (i < err_cyc.size()) ? err_cyc[i] : -1000;
  endfunction

  task automatic model_step();
    if (!rstn) begin
      m_busy = 0; m_gap = 0; m_ptr = 0; m_owner = 0;
      m_left = 0; m_stall = 0; m_done = 0; m_err = 0;
    end else begin
      cyc++;
      m_done = 0;
      m_err  = 0;
      if (m_busy != 0) begin
        if (ack_o) begin
          m_left--;
          m_stall = 0;
          if (m_left == 0) begin
            m_busy = 0; m_gap = 1; m_done = 1;
            m_ptr = (m_owner + 1) % N;
          end
        end else begin
          m_stall++;
          if (m_stall >= (1 << TOW) - 1) begin
            m_busy = 0; m_gap = 1; m_err = 1;
            m_ptr = (m_owner + 1) % N;
          end
        end
      end else if (m_gap != 0) begin
        m_gap = 0;
      end else if (req_i != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req_i[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_busy  = 1;
        m_left  = len_of(m_owner) + 1;
        m_stall = 0;
        grant_log.push_back(m_owner);
        grant_cyc.push_back(cyc);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (busy_o && ack_o) dut_beats++;
    if (done_o) dut_done++;
    if (err_o) begin
      dut_err++;
      err_cyc.push_back(cyc);
    end
    if (cmp_en) begin
      chk("gnt",  int'(gnt_o),  (m_busy != 0) ? (1 << m_owner) : 0);
      chk("busy", int'(busy_o), m_busy);
      chk("req",  int'(req_o),  m_busy);
      chk("last", int'(last_o), ((m_busy != 0) && (m_left == 1)) ? 1 : 0);
      chk("done", int'(done_o), m_done);
      chk("err",  int'(err_o),  m_err);
      if (m_busy != 0) chk("owner", int'(owner_o), m_owner);
    end
  end

  task automatic mark();
    base_g = grant_log.size();
    base_b = dut_beats;
    base_d = dut_done;
    base_e = dut_err;
  endtask

  task automatic wait_grants(input int n, input int bound);
    int k = 0;
    while (grant_log.size() < base_g + n && k < bound) begin
      @(posedge clk); #2;
      k++;
    end
    chk("grant_wait", (grant_log.size() >= base_g + n) ? 1 : 0, 1);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    req_i = '0;
    while ((m_busy != 0 || m_gap != 0) && k < bound) begin
      @(posedge clk); #2;
      k++;
    end
    chk("drain_idle", (m_busy != 0 || m_gap != 0) ? 1 : 0, 0);
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn = 1'b1; req_i = '0; len_i = '0; ack_o = 1'b0;
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    chk("rst_gnt",   int'(gnt_o),   0);
    chk("rst_owner", int'(owner_o), 0);
    chk("rst_busy",  int'(busy_o),  0);
    chk("rst_req",   int'(req_o),   0);
    chk("rst_last",  int'(last_o),  0);
    chk("rst_done",  int'(done_o),  0);
    chk("rst_err",   int'(err_o),   0);
    rstn = 1'b1;

    // two requesters, single-beat bursts: 1,2,1 with 3-cycle spacing
    mark();
    len_i = '0; ack_o = 1'b1; req_i = 4'b0110;
    wait_grants(3, 40);
    drain(40);
    chk("t1_g0", glog(base_g),     1);
    chk("t1_g1", glog(base_g + 1), 2);
    chk("t1_g2", glog(base_g + 2), 1);
    chk("t1_ngrants", grant_log.size() - base_g, 3);
    chk("t1_sp0", gcyc(base_g + 1) - gcyc(base_g), 3);
    chk("t1_sp1", gcyc(base_g + 2) - gcyc(base_g + 1), 3);
    chk("t1_done", dut_done - base_d, 3);

    // all requesting, len_i[i]=i: 0,1,2,3,0 with 1..4 beats
    do_reset();
    mark();
    len_i = 16'h3210; ack_o = 1'b1; req_i = 4'b1111;
    wait_grants(5, 60);
    drain(40);
    chk("t2_g0", glog(base_g),     0);
    chk("t2_g1", glog(base_g + 1), 1);
    chk("t2_g2", glog(base_g + 2), 2);
    chk("t2_g3", glog(base_g + 3), 3);
    chk("t2_g4", glog(base_g + 4), 0);
    chk("t2_sp0", gcyc(base_g + 1) - gcyc(base_g),     3);
    chk("t2_sp1", gcyc(base_g + 2) - gcyc(base_g + 1), 4);
    chk("t2_sp2", gcyc(base_g + 3) - gcyc(base_g + 2), 5);
    chk("t2_sp3", gcyc(base_g + 4) - gcyc(base_g + 3), 6);
    chk("t2_beats", dut_beats - base_b, 11);
    chk("t2_done", dut_done - base_d, 5);

    // owner 3 completes with 1001 pending: pointer wraps to 0
    mark();
    req_i = 4'b1000;
    wait_grants(1, 20);
    req_i = 4'b1001;
    wait_grants(2, 40);
    chk("t3_owner_lit", int'(owner_o), 0);
    chk("t3_gnt_lit",   int'(gnt_o),   1);
    drain(40);
    chk("t3_g0", glog(base_g),     3);
    chk("t3_g1", glog(base_g + 1), 0);
    chk("t3_sp", gcyc(base_g + 1) - gcyc(base_g), 6);

    // requester 2, len 3, toggling ack, request dropped mid-burst
    mark();
    len_i = 16'h0300; ack_o = 1'b0; req_i = 4'b0100;
    wait_grants(1, 20);
    for (int k = 0; k < 12; k++) begin
      ack_o = (k % 2 == 0);
      if (k == 3) req_i = '0;
      @(posedge clk); #2;
    end
    ack_o = 1'b0;
    drain(20);
    chk("t4_g0", glog(base_g), 2);
    chk("t4_ngrants", grant_log.size() - base_g, 1);
    chk("t4_beats", dut_beats - base_b, 4);
    chk("t4_done", dut_done - base_d, 1);

    // watchdog abort: 7 stalled cycles, then the other requester wins
    mark();
    len_i = '0; ack_o = 1'b0; req_i = 4'b0011;
    wait_grants(2, 40);
    drain(30);
    chk("t5_g0", glog(base_g),     0);
    chk("t5_g1", glog(base_g + 1), 1);
    chk("t5_err0_lat", ecyc(base_e) - gcyc(base_g), 7);
    chk("t5_err1_lat", ecyc(base_e + 1) - gcyc(base_g + 1), 7);
    chk("t5_sp", gcyc(base_g + 1) - gcyc(base_g), 9);
    chk("t5_err", dut_err - base_e, 2);
    chk("t5_done", dut_done - base_d, 0);

    // ack on the saturating cycle wins; two beats, no abort
    mark();
    len_i = 16'h0001; ack_o = 1'b0; req_i = 4'b0001;
    wait_grants(1, 20);
    for (int k = 0; k < 14; k++) begin
      ack_o = (k == 6 || k == 13);
      if (k == 0) req_i = '0;
      @(posedge clk); #2;
    end
    ack_o = 1'b0;
    drain(20);
    chk("t6_g0", glog(base_g), 0);
    chk("t6_err", dut_err - base_e, 0);
    chk("t6_done", dut_done - base_d, 1);
    chk("t6_beats", dut_beats - base_b, 2);

    // maximum length: 16 beats, no counter underflow
    mark();
    len_i = 16'h0F00; ack_o = 1'b1; req_i = 4'b0100;
    wait_grants(1, 20);
    drain(40);
    chk("t7_g0", glog(base_g), 2);
    chk("t7_beats", dut_beats - base_b, 16);
    chk("t7_done", dut_done - base_d, 1);

    // reset mid-burst: outputs clear at once, pointer back to 0
    mark();
    len_i = 16'hF000; ack_o = 1'b1; req_i = 4'b1010;
    wait_grants(1, 20);
    chk("t8_g0", glog(base_g), 3);
    repeat (3) begin @(posedge clk); #2; end
    mark();
    #1 rstn = 1'b0;
    #1;
    chk("t8_gnt",   int'(gnt_o),   0);
    chk("t8_owner", int'(owner_o), 0);
    chk("t8_busy",  int'(busy_o),  0);
    chk("t8_req",   int'(req_o),   0);
    chk("t8_last",  int'(last_o),  0);
    chk("t8_done",  int'(done_o),  0);
    chk("t8_err",   int'(err_o),   0);
    @(posedge clk); #2;
    rstn = 1'b1;
    wait_grants(1, 20);
    chk("t8_first_after_rst", glog(base_g), 1);
    drain(20);
    chk("t8_done_cnt", dut_done - base_d, 1);
    chk("t8_err_cnt", dut_err - base_e, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
